// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, word geometry and the request error check.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int OFF_W  = 2;

    localparam logic [WORD_W-1:0] ZERO_DATA = '0;
    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_HIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misaligned, or word address beyond the array.
    function automatic logic addr_err(
        input logic [WORD_W-1:0] addr,
        input int                depth
    );
        logic [WORD_W-OFF_W-1:0] word;
        word = addr[WORD_W-1:OFF_W];
        if (addr[OFF_W-1:0] != '0)
            return ERR_HIT;
        if (word >= (WORD_W-OFF_W)'(depth))
            return ERR_HIT;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with registered read.
// Contents are not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_idx,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_idx] <= i_wdata;
        r_rdata <= r_mem[i_idx];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder for the memory stage.
// One request in flight; response held until taken.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;

    logic              r_we;
    logic              r_err_l;
    logic [AW-1:0]     r_idx;
    logic [WORD_W-1:0] r_wdata;

    logic [WORD_W-1:0] r_rdata;
    logic              r_err;

    logic              w_idle;
    logic              w_accept;
    logic              w_last;
    logic              w_done;
    logic              w_ram_we;
    logic [AW-1:0]     w_ram_idx;
    logic [WORD_W-1:0] w_ram_rdata;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && rst && req_valid;
    assign w_last   = (r_state == BUSY) && (r_cnt == CNT_LAST);
    assign w_done   = (r_state == RESP) && rsp_ready;

    // Reads run ahead from the accept edge so LATENCY = 1 still works.
    assign w_ram_idx = w_idle ? req_addr[OFF_W +: AW] : r_idx;
    assign w_ram_we  = w_last && rst && r_we && (r_err_l == ERR_NONE);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (req_valid) w_next = BUSY;
            BUSY: if (w_last)    w_next = RESP;
            RESP: if (rsp_ready) w_next = IDLE;
            default:             w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt <= '0;
        else if ((r_state == BUSY) && !w_last)
            r_cnt <= r_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_err_l <= addr_err(req_addr, DEPTH);
            r_idx   <= req_addr[OFF_W +: AW];
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= ZERO_DATA;
            r_err   <= ERR_NONE;
        end else if (w_last) begin
            r_rdata <= (r_we || r_err_l) ? ZERO_DATA : w_ram_rdata;
            r_err   <= r_err_l;
        end else if (w_done) begin
            r_rdata <= ZERO_DATA;
            r_err   <= ERR_NONE;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_ram_we),
        .i_idx   (w_ram_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign req_ready = w_idle && rst;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving load/store requests issued by the pipeline memory stage. Accepts one request at a time over a valid/ready handshake, waits a fixed access latency, then returns read data or a write acknowledgement over a held response channel. Provides the slave end of the memory-stage-to-data-memory interface, so the memory stage can be exercised against realistic, non-zero-latency memory.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, at least 4.
- LATENCY, 2: BUSY cycles between request acceptance and response; at least 1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising clk edge.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store (Mem_W), 0 = load (Mem_R).
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.

## Operation
- FSM has three states.
  - IDLE: req_ready = 1. If req_valid, latch we/addr/wdata, clear the counter, and go to BUSY.
  - BUSY: req_ready = 0. Count LATENCY cycles, then go to RESP.
  - RESP: rsp_valid = 1. When rsp_ready, go to IDLE.
- Word index is req_addr[2 +: log2(DEPTH)].
- Error condition: req_addr[1:0] != 0, or req_addr[31:2] >= DEPTH.
  - Evaluated at acceptance; the result is latched.
  - An errored store does not write the array.
  - An errored load returns rdata 0.
  - Latency is unchanged on error.
- Stores write the array on the final BUSY edge. rsp_rdata = 0, rsp_err = 0.
- Loads read the array during the final BUSY cycle. rsp_rdata is registered on entry to RESP.
- rsp_valid, rsp_rdata and rsp_err are held stable throughout RESP until the handshake completes.
- Request inputs are ignored outside IDLE. The requester holds them until req_ready, but the responder does not depend on that.
- The array is not cleared by reset. Reading a location never written returns an undefined value.

## Timing
- Reset (rst = 0 at an edge):
  - State goes to IDLE; the counter goes to 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 0 while rst is low; req_ready = 1 from the first cycle after release.
- Request accepted at edge T (IDLE, req_valid):
  - BUSY spans cycles T+1 .. T+LATENCY.
  - rsp_valid rises after edge T+LATENCY.
  - Minimum round trip is LATENCY+1 cycles, including a 1-cycle RESP.
- Back-pressure: if rsp_ready = 0, RESP holds indefinitely and no new request is accepted.
- The response handshake at edge U returns the FSM to IDLE. req_ready = 1 from cycle U+1. There is no RESP-to-accept bypass.
- Store followed by a load to the same address returns the new data, because the write completes before the load is accepted.
- Reset mid-BUSY or mid-RESP:
  - The transaction is abandoned and no response is issued.
  - A store reset before its final BUSY edge does not write.
  - Reset has priority over all other transitions on the same edge.
- req_valid asserted together with reset release is not accepted, because req_ready was 0 during reset.

## Structure
- Package dmem_pkg contains:
  - state encoding: IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
  - word width (32) and byte-offset width (2);
  - error/zero-data constants.
- Sub-module dmem_array: synchronous single-port RAM, parameterised by DEPTH.
  - Ports: clk, we, word index, wdata, rdata.
  - Registered read, no reset.
- dmem_responder holds the FSM, the latency counter, the request latches, the error check and the response registers.

## Test plan
- Reset: hold rst = 0 for 2 cycles with req_valid = 1. Expect req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and no response. After release, req_ready = 1.
- Store then load: store addr 10→ use aligned 0x28, wdata 100; then load 0x28.
  - The store response (rdata 0, err 0) arrives exactly LATENCY+1 cycles after acceptance.
  - The load returns 100.
  - Repeat with 0x50 / 200.
- Back-pressure: load 0x28 with rsp_ready = 0 for 5 cycles.
  - rsp_valid and rsp_rdata = 100 stay stable.
  - req_valid is held 1 but req_ready stays 0.
  - Release rsp_ready. IDLE follows on the next cycle.
- Errors:
  - Store to 0x2A (misaligned) gives rsp_err = 1; a subsequent load of 0x28 still returns 100.
  - Load of DEPTH*4 gives rsp_err = 1, rdata 0.
- Reset mid-transaction: accept a store of 0x3C / 0xDEAD, then assert rst during the first BUSY cycle.
  - No rsp_valid is issued.
  - After a store of 0x3C / 0x1234, a load of 0x3C returns 0x1234; no response from the aborted store appears at any point.
- LATENCY = 1 and LATENCY = 4 builds: the round trip measures 2 and 5 cycles respectively with rsp_ready tied to 1.
